// File: rtl/fs_cap.sv
// fs_cap_mc -- multi-channel frame-sync capture.
//
// Each VS input is synchronised, glitch-filtered, edge-detected with a
// per-channel polarity, counted, and watched by a sticky missing-frame
// watchdog. Channels are fully independent; one fs_cap_ch instance per channel.
//
// Ports (top):
//   clk_i        system clock, all logic on this clock
//   rst_i        synchronous active-high reset
//   vs_i         asynchronous VS inputs, bit n = channel n
//   en_i         per-channel enable
//   pol_i        per-channel polarity (1 = rising edge is frame start)
//   mode_i       0 = one-cycle frame-start pulse, 1 = filtered level pass-through
//   clr_i        clears frame counters, watchdog counters and timeout flags
//   to_limit_i   watchdog limit in cycles, 0 disables
//   fs_cap_o     frame-start pulse / gated filtered level
//   vs_lvl_o     filtered VS level (ignores en_i and mode_i)
//   frame_cnt_o  packed frame counters, channel n at [n*CNT_W +: CNT_W]
//   timeout_o    sticky watchdog flags

module fs_cap_ch #(
    parameter int SYNC_STAGES = 4,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 16,
    parameter int TO_W        = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vs_i,
    input  logic             en_i,
    input  logic             pol_i,
    input  logic             mode_i,
    input  logic             clr_i,
    input  logic [TO_W-1:0]  to_limit_i,
    output logic             fs_cap_o,
    output logic             vs_lvl_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             timeout_o
);
    localparam int FW = $clog2(FILT_LEN + 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic          synced;
    logic [FW-1:0] filt_cnt;
    logic          lvl_q;
    logic          lvl_d;
    logic          edge_ev;
    logic          ev;
    logic [TO_W-1:0] wd_q;
    logic [TO_W-1:0] wd_nxt;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], vs_i};
    end

    // A new level is accepted only after FILT_LEN consecutive mismatching
    // cycles; any matching cycle restarts the run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_cnt <= '0;
            lvl_q    <= 1'b0;
        end else if (synced != lvl_q) begin
            if (filt_cnt == FW'(FILT_LEN - 1)) begin
                lvl_q    <= synced;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Polarity only selects which transition counts, so flipping pol_i while
    // the level is stable never produces an event.
    assign edge_ev = pol_i ? (lvl_q & ~lvl_d) : (~lvl_q & lvl_d);
    assign ev      = edge_ev & en_i;

    always_comb begin
        wd_nxt = '0;
        if (en_i && !ev) wd_nxt = (&wd_q) ? wd_q : wd_q + TO_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lvl_d       <= 1'b0;
            fs_cap_o    <= 1'b0;
            frame_cnt_o <= '0;
            wd_q        <= '0;
            timeout_o   <= 1'b0;
        end else begin
            lvl_d    <= lvl_q;
            fs_cap_o <= mode_i ? (lvl_q & en_i) : ev;
            if (clr_i) begin
                frame_cnt_o <= '0;
                wd_q        <= '0;
                timeout_o   <= 1'b0;
            end else begin
                if (ev) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
                wd_q <= wd_nxt;
                if (en_i && (to_limit_i != '0) && (wd_nxt == to_limit_i))
                    timeout_o <= 1'b1;
            end
        end
    end

    assign vs_lvl_o = lvl_q;
endmodule

module fs_cap_mc #(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 4,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 16,
    parameter int TO_W        = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CH_NUM-1:0]       vs_i,
    input  logic [CH_NUM-1:0]       en_i,
    input  logic [CH_NUM-1:0]       pol_i,
    input  logic                    mode_i,
    input  logic                    clr_i,
    input  logic [TO_W-1:0]         to_limit_i,
    output logic [CH_NUM-1:0]       fs_cap_o,
    output logic [CH_NUM-1:0]       vs_lvl_o,
    output logic [CH_NUM*CNT_W-1:0] frame_cnt_o,
    output logic [CH_NUM-1:0]       timeout_o
);
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        fs_cap_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .CNT_W       (CNT_W),
            .TO_W        (TO_W)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .vs_i        (vs_i[g]),
            .en_i        (en_i[g]),
            .pol_i       (pol_i[g]),
            .mode_i      (mode_i),
            .clr_i       (clr_i),
            .to_limit_i  (to_limit_i),
            .fs_cap_o    (fs_cap_o[g]),
            .vs_lvl_o    (vs_lvl_o[g]),
            .frame_cnt_o (frame_cnt_o[g*CNT_W +: CNT_W]),
            .timeout_o   (timeout_o[g])
        );
    end
endmodule

// File: tb/tb_fs_cap_mc.sv
// Directed bench for fs_cap_mc: a vector table for single-channel pulse
// scenarios plus hand-written sequences for latency, polarity, mode 1,
// watchdog, clear priority, wrap/enable and mid-filter reset.
module tb_fs_cap_mc;
    localparam int CH  = 4;
    localparam int SS  = 4;
    localparam int FL  = 4;
    localparam int CW  = 4;
    localparam int TW  = 24;
    localparam int LAT = SS + FL + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    vs, en, pol;
    logic             mode, clr;
    logic [TW-1:0]    to_limit;
    logic [CH-1:0]    fs_cap, vs_lvl, timeout;
    logic [CH*CW-1:0] frame_cnt;

    fs_cap_mc #(.CH_NUM(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW), .TO_W(TW)) dut (
        .clk_i(clk), .rst_i(rst), .vs_i(vs), .en_i(en), .pol_i(pol), .mode_i(mode),
        .clr_i(clr), .to_limit_i(to_limit), .fs_cap_o(fs_cap), .vs_lvl_o(vs_lvl),
        .frame_cnt_o(frame_cnt), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic int cnt_of(input int ch);
        return int'(frame_cnt[ch*CW +: CW]);
    endfunction

    typedef struct {
        int ch;
        bit pol;
        int len;         // cycles vs is held high
        int exp_pulses;  // pulses on fs_cap[ch] in the window
        bit exp_lvl;     // whether vs_lvl[ch] ever rises
    } vec_t;

    vec_t vt[6];
    int pulses, other, c0, rises, ch, len;
    bit lvl_seen, prev;
    logic [CH-1:0] mask;

    initial begin
        vt[0] = '{ch:1, pol:1'b1, len:3,  exp_pulses:0, exp_lvl:1'b0};
        vt[1] = '{ch:1, pol:1'b1, len:4,  exp_pulses:1, exp_lvl:1'b1};
        vt[2] = '{ch:2, pol:1'b0, len:10, exp_pulses:1, exp_lvl:1'b1};
        vt[3] = '{ch:3, pol:1'b1, len:1,  exp_pulses:0, exp_lvl:1'b0};
        vt[4] = '{ch:3, pol:1'b0, len:5,  exp_pulses:1, exp_lvl:1'b1};
        vt[5] = '{ch:2, pol:1'b0, len:3,  exp_pulses:0, exp_lvl:1'b0};

        rst = 1'b1; vs = '0; en = '1; pol = '1; mode = 1'b0; clr = 1'b0; to_limit = '0;
        tick(3);
        chk("rst fs_cap", fs_cap, 0);
        chk("rst vs_lvl", vs_lvl, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst timeout", timeout, 0);
        rst = 1'b0;
        tick(2);

        // Latency on ch0: pulse exactly on edge LAT after first sample.
        vs[0] = 1'b1;
        tick(LAT - 1);
        chk("lat pre", fs_cap, 0);
        tick(1);
        chk("lat pulse", fs_cap, 4'b0001);
        tick(1);
        chk("lat post", fs_cap, 0);
        tick(10);
        chk("lat cnt0", cnt_of(0), 1);
        chk("lat cnt others", frame_cnt[CH*CW-1:CW], 0);
        vs[0] = 1'b0;
        tick(15);
        chk("fall pol1 cnt0", cnt_of(0), 1);

        // Table: single pulse on one channel, observed for a fixed window.
        for (int i = 0; i < 6; i++) begin
            ch = vt[i].ch; len = vt[i].len;
            pol[ch] = vt[i].pol;
            mask = '1; mask[ch] = 1'b0;
            tick(2);
            c0 = cnt_of(ch); pulses = 0; other = 0; lvl_seen = 1'b0;
            vs[ch] = 1'b1;
            for (int t = 0; t < len + 30; t++) begin
                if (t == len) vs[ch] = 1'b0;
                tick(1);
                if (fs_cap[ch]) pulses++;
                if ((fs_cap & mask) != '0) other++;
                if (vs_lvl[ch]) lvl_seen = 1'b1;
            end
            chk($sformatf("vec%0d pulses", i), pulses, vt[i].exp_pulses);
            chk($sformatf("vec%0d other", i), other, 0);
            chk($sformatf("vec%0d lvl", i), lvl_seen, vt[i].exp_lvl);
            chk($sformatf("vec%0d cnt", i), cnt_of(ch), (c0 + vt[i].exp_pulses) % 16);
        end

        // Falling-polarity pulse aligned to the falling transition.
        pol[2] = 1'b0; vs[2] = 1'b1;
        tick(20);
        vs[2] = 1'b0;
        tick(LAT - 1);
        chk("pol0 pre", fs_cap[2], 0);
        tick(1);
        chk("pol0 pulse", fs_cap[2], 1);
        tick(1);
        chk("pol0 post", fs_cap[2], 0);

        // Flipping pol with a stable level must not create an event.
        vs[2] = 1'b1;
        tick(20);
        pulses = 0;
        pol[2] = 1'b1;
        for (int t = 0; t < 5; t++) begin tick(1); if (fs_cap[2]) pulses++; end
        pol[2] = 1'b0;
        for (int t = 0; t < 5; t++) begin tick(1); if (fs_cap[2]) pulses++; end
        chk("pol flip no event", pulses, 0);
        vs[2] = 1'b0;
        tick(20);

        // Mode 1: fs_cap follows the filtered level, delayed LAT cycles.
        mode = 1'b1; vs[2] = 1'b1;
        tick(LAT - 1);
        chk("mode1 rise pre", fs_cap[2], 0);
        tick(1);
        chk("mode1 rise", fs_cap[2], 1);
        tick(10);
        chk("mode1 hold", fs_cap[2], 1);
        vs[2] = 1'b0;
        tick(LAT - 1);
        chk("mode1 fall pre", fs_cap[2], 1);
        tick(1);
        chk("mode1 fall", fs_cap[2], 0);
        mode = 1'b0; pol = '1;
        tick(5);

        // Watchdog: limit 100, all channels idle from reset release.
        rst = 1'b1; to_limit = TW'(100);
        tick(2);
        rst = 1'b0;
        tick(99);
        chk("wd cycle99", timeout, 0);
        tick(1);
        chk("wd cycle100", timeout, 4'hF);
        vs[3] = 1'b1;
        tick(12);
        vs[3] = 1'b0;
        tick(20);
        chk("wd sticky", timeout[3], 1);
        chk("wd cnt3", cnt_of(3), 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr timeout", timeout, 0);
        chk("clr frame_cnt", frame_cnt, 0);
        // clr on the same edge as an event: pulse still seen, count stays 0.
        vs[3] = 1'b1;
        tick(LAT - 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr+ev pulse", fs_cap[3], 1);
        chk("clr+ev cnt3", cnt_of(3), 0);
        to_limit = '0;
        vs[3] = 1'b0;
        tick(15);

        // Wrap on the 4-bit counter, then disable ch0.
        clr = 1'b1; tick(1); clr = 1'b0;
        for (int f = 0; f < 17; f++) begin
            vs[0] = 1'b1; tick(10);
            vs[0] = 1'b0; tick(10);
            if (f == 15) chk("wrap 16 frames", cnt_of(0), 0);
        end
        chk("wrap 17 frames", cnt_of(0), 1);
        en[0] = 1'b0;
        pulses = 0; rises = 0; prev = vs_lvl[0];
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 20; t++) begin
                vs[0] = (t < 10);
                tick(1);
                if (fs_cap[0]) pulses++;
                if (vs_lvl[0] && !prev) rises++;
                prev = vs_lvl[0];
            end
        end
        chk("dis pulses", pulses, 0);
        chk("dis lvl rises", rises, 2);
        chk("dis cnt hold", cnt_of(0), 1);
        en[0] = 1'b1;
        tick(15);

        // Reset two cycles into a filter run aborts it.
        vs[1] = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(1);
        chk("midrst fs_cap", fs_cap, 0);
        chk("midrst vs_lvl", vs_lvl, 0);
        chk("midrst frame_cnt", frame_cnt, 0);
        chk("midrst timeout", timeout, 0);
        rst = 1'b0;
        pulses = 0;
        for (int t = 0; t < LAT - 1; t++) begin tick(1); if (fs_cap[1]) pulses++; end
        chk("midrst no early", pulses, 0);
        tick(1);
        chk("midrst fresh pulse", fs_cap[1], 1);
        tick(1);
        chk("midrst cnt1", cnt_of(1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
